// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin N-to-1 stream multiplexer.
//   sel_width : width of a channel index for a given channel count (min 1)
//   next_ptr  : wrapped increment of a channel index, valid for any count
package rr_mux_pkg;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Explicit wrap so non-power-of-2 channel counts never reach index n.
  function automatic int unsigned next_ptr(input int unsigned idx,
                                           input int unsigned n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_mux_nx1_rr_pick.sv
// Combinational rotating-priority encoder.
//   req         : request vector, one bit per channel
//   ptr         : channel with highest priority (must be < NUM_CH)
//   grant_valid : at least one request present
//   grant       : first requesting channel at or above ptr, wrapping to 0
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              grant_valid,
  output logic [SEL_W-1:0]  grant
);

  int unsigned      idx;
  logic [SEL_W-1:0] sel;

  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = 0;
    sel         = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      sel = SEL_W'(idx);
      if (!grant_valid && req[sel]) begin
        grant_valid = 1'b1;
        grant       = sel;
      end
    end
  end

endmodule

// File: rtl/rr_mux_nx1.sv
// Parametrised N-to-1 stream multiplexer with round-robin or forced channel
// selection and a registered output stage.
//   clk, rst  : clock, synchronous active-high reset
//   in_data   : packed channel data, channel k at [k*DATA_W +: DATA_W]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready, one-hot or zero
//   force_en  : restrict eligibility to channel force_sel
//   force_sel : forced channel index (out-of-range index grants nothing)
//   out_data  : registered output word
//   out_ch    : channel that sourced out_data
//   out_valid : output valid
//   out_ready : consumer ready
module rr_mux_nx1
  import rr_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = sel_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     force_en,
  input  logic [SEL_W-1:0]         force_sel,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic [SEL_W-1:0]  ptr;
  logic [NUM_CH-1:0] req;
  logic              grant_valid;
  logic [SEL_W-1:0]  grant;
  logic              load;

  assign load = !out_valid || out_ready;

  always_comb begin
    req = '0;
    if (force_en) begin
      if (int'(force_sel) < NUM_CH) req[force_sel] = in_valid[force_sel];
    end else begin
      req = in_valid;
    end
  end

  rr_pick #(
    .NUM_CH(NUM_CH),
    .SEL_W (SEL_W)
  ) u_pick (
    .req        (req),
    .ptr        (ptr),
    .grant_valid(grant_valid),
    .grant      (grant)
  );

  always_comb begin
    in_ready = '0;
    if (!rst && load && grant_valid) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (grant_valid) begin
        out_data  <= in_data[grant*DATA_W +: DATA_W];
        out_ch    <= grant;
        out_valid <= 1'b1;
        ptr       <= SEL_W'(next_ptr(int'(grant), NUM_CH));
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_nx1.sv
module tb_rr_mux_nx1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic        force_en;
  logic [1:0]  force_sel;
  logic        out_ready;

  logic [3:0]  in_ready4;
  logic [7:0]  out_data4;
  logic [1:0]  out_ch4;
  logic        out_valid4;

  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;

  rr_mux_nx1 #(.NUM_CH(4), .DATA_W(8)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready4), .force_en(force_en), .force_sel(force_sel),
    .out_data(out_data4), .out_ch(out_ch4), .out_valid(out_valid4),
    .out_ready(out_ready)
  );

  rr_mux_nx1 #(.NUM_CH(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data[23:0]), .in_valid(in_valid[2:0]),
    .in_ready(in_ready3), .force_en(force_en), .force_sel(force_sel),
    .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
    .out_ready(out_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, index 0 = 4-channel build, 1 = 3-channel build
  bit          m_valid[2] = '{0, 0};
  int          m_ptr[2]   = '{0, 0};
  int          m_g[2]     = '{-1, -1};
  bit          m_ld[2]    = '{0, 0};
  logic [9:0]  q4[$];
  logic [9:0]  q3[$];

  int          mn, mg, midx;
  bit          mel;
  logic [3:0]  exp_rdy, act_rdy;
  logic        act_valid;
  logic [9:0]  act_word, exp_word;

  // Monitor: grant prediction, ready check, and scoreboard pop on consume
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      mn = (d == 0) ? 4 : 3;
      mg = -1;
      for (int i = 0; i < mn; i++) begin
        midx = (m_ptr[d] + i) % mn;
        mel  = force_en ? (int'(force_sel) == midx && in_valid[midx])
                        : in_valid[midx];
        if (mg < 0 && mel) mg = midx;
      end
      m_g[d]  = mg;
      m_ld[d] = !m_valid[d] || out_ready;
      exp_rdy = (!rst && m_ld[d] && mg >= 0) ? (4'b0001 << mg) : 4'b0000;
      act_rdy   = (d == 0) ? in_ready4 : {1'b0, in_ready3};
      act_valid = (d == 0) ? out_valid4 : out_valid3;
      act_word  = (d == 0) ? {out_ch4, out_data4} : {out_ch3, out_data3};

      n_checks++;
      if (act_rdy !== exp_rdy)
        $display("FAIL mon_ready[%0d] t=%0t got %b want %b", d, $time, act_rdy, exp_rdy);
      else n_pass++;

      n_checks++;
      if (act_valid !== m_valid[d])
        $display("FAIL mon_valid[%0d] t=%0t got %b want %b", d, $time, act_valid, m_valid[d]);
      else n_pass++;

      if (!rst && m_valid[d] && out_ready) begin
        n_checks++;
        if ((d == 0 ? q4.size() : q3.size()) == 0) begin
          $display("FAIL mon_word[%0d] t=%0t got %h want <none queued>", d, $time, act_word);
        end else begin
          exp_word = (d == 0) ? q4.pop_front() : q3.pop_front();
          if (act_word !== exp_word)
            $display("FAIL mon_word[%0d] t=%0t got ch=%0d data=%h want ch=%0d data=%h",
                     d, $time, act_word[9:8], act_word[7:0], exp_word[9:8], exp_word[7:0]);
          else n_pass++;
        end
      end
    end
  end

  // Model state update on the active edge; expected words are queued here
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_valid[d] = 1'b0;
        m_ptr[d]   = 0;
        if (d == 0) q4.delete(); else q3.delete();
      end else if (m_ld[d]) begin
        if (m_g[d] >= 0) begin
          if (d == 0) q4.push_back({2'(m_g[d]), in_data[m_g[d]*8 +: 8]});
          else        q3.push_back({2'(m_g[d]), in_data[m_g[d]*8 +: 8]});
          m_valid[d] = 1'b1;
          m_ptr[d]   = (m_g[d] + 1) % ((d == 0) ? 4 : 3);
        end else begin
          m_valid[d] = 1'b0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    n_checks++; if (in_ready4 !== 4'b0000) $display("FAIL reset_ready got %b want 0000", in_ready4); else n_pass++;
    n_checks++; if (out_valid4 !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid4); else n_pass++;
    n_checks++; if (out_data4 !== 8'h00) $display("FAIL reset_data got %h want 00", out_data4); else n_pass++;
    n_checks++; if (out_ch4 !== 2'd0) $display("FAIL reset_ch got %0d want 0", out_ch4); else n_pass++;
    n_checks++; if (in_ready3 !== 3'b000) $display("FAIL reset_ready3 got %b want 000", in_ready3); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready4 !== 4'b0001) $display("FAIL post_reset_ready got %b want 0001", in_ready4); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp;
    for (int i = 0; i < 5; i++) begin
      cyc();
      exp = 8'((i % 4 + 1) * 8'h11);
      n_checks++; if (out_valid4 !== 1'b1) $display("FAIL rr_valid[%0d] got %b want 1", i, out_valid4); else n_pass++;
      n_checks++; if (out_ch4 !== 2'(i % 4)) $display("FAIL rr_ch[%0d] got %0d want %0d", i, out_ch4, i % 4); else n_pass++;
      n_checks++; if (out_data4 !== exp) $display("FAIL rr_data[%0d] got %h want %h", i, out_data4, exp); else n_pass++;
      n_checks++; if (out_ch3 !== 2'(i % 3)) $display("FAIL rr3_ch[%0d] got %0d want %0d", i, out_ch3, i % 3); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    cyc();
    n_checks++; if (out_ch4 !== 2'd1) $display("FAIL bp_setup_ch got %0d want 1", out_ch4); else n_pass++;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (in_ready4 !== 4'b0000) $display("FAIL bp_ready[%0d] got %b want 0000", i, in_ready4); else n_pass++;
      cyc();
      n_checks++; if (out_ch4 !== 2'd1) $display("FAIL bp_ch[%0d] got %0d want 1", i, out_ch4); else n_pass++;
      n_checks++; if (out_data4 !== 8'h22) $display("FAIL bp_data[%0d] got %h want 22", i, out_data4); else n_pass++;
      n_checks++; if (out_valid4 !== 1'b1) $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid4); else n_pass++;
    end
    out_ready = 1'b1;
    cyc();
    n_checks++; if (out_ch4 !== 2'd2) $display("FAIL bp_resume_ch got %0d want 2", out_ch4); else n_pass++;
    n_checks++; if (out_data4 !== 8'h33) $display("FAIL bp_resume_data got %h want 33", out_data4); else n_pass++;
  endtask

  task automatic test_sparse();
    logic [1:0] exp_ch [3];
    exp_ch[0] = 2'd1; exp_ch[1] = 2'd3; exp_ch[2] = 2'd1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++; if (out_ch4 !== exp_ch[i]) $display("FAIL sparse_ch[%0d] got %0d want %0d", i, out_ch4, exp_ch[i]); else n_pass++;
    end
    in_valid = 4'b0000;
    cyc();
    n_checks++; if (out_valid4 !== 1'b0) $display("FAIL sparse_drain_valid got %b want 0", out_valid4); else n_pass++;
    n_checks++; if (out_ch4 !== 2'd1) $display("FAIL sparse_hold_ch got %0d want 1", out_ch4); else n_pass++;
    n_checks++; if (out_data4 !== 8'h22) $display("FAIL sparse_hold_data got %h want 22", out_data4); else n_pass++;
  endtask

  task automatic test_force();
    in_valid  = 4'b1111;
    force_en  = 1'b1;
    force_sel = 2'd2;
    #1;
    n_checks++; if (in_ready4 !== 4'b0100) $display("FAIL force_ready got %b want 0100", in_ready4); else n_pass++;
    n_checks++; if (in_ready3 !== 3'b100) $display("FAIL force_ready3 got %b want 100", in_ready3); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++; if (out_ch4 !== 2'd2) $display("FAIL force_ch[%0d] got %0d want 2", i, out_ch4); else n_pass++;
      n_checks++; if (out_data4 !== 8'h33) $display("FAIL force_data[%0d] got %h want 33", i, out_data4); else n_pass++;
      n_checks++; if (in_ready4 !== 4'b0100) $display("FAIL force_hold_ready[%0d] got %b want 0100", i, in_ready4); else n_pass++;
    end
    in_valid = 4'b1011;
    cyc();
    n_checks++; if (out_valid4 !== 1'b0) $display("FAIL force_novalid got %b want 0", out_valid4); else n_pass++;
    n_checks++; if (in_ready4 !== 4'b0000) $display("FAIL force_noready got %b want 0000", in_ready4); else n_pass++;
    in_valid  = 4'b1111;
    force_sel = 2'd3;
    #1;
    n_checks++; if (in_ready4 !== 4'b1000) $display("FAIL force3_ready got %b want 1000", in_ready4); else n_pass++;
    n_checks++; if (in_ready3 !== 3'b000) $display("FAIL force_oob_ready3 got %b want 000", in_ready3); else n_pass++;
    cyc();
    n_checks++; if (out_ch4 !== 2'd3) $display("FAIL force3_ch got %0d want 3", out_ch4); else n_pass++;
    n_checks++; if (out_valid3 !== 1'b0) $display("FAIL force_oob_valid3 got %b want 0", out_valid3); else n_pass++;
    force_en = 1'b0;
  endtask

  task automatic test_three_ch();
    logic [1:0] e;
    in_valid = 4'b1111;
    cyc();
    cyc();
    n_checks++; if (out_valid3 !== 1'b1) $display("FAIL tc_pre_valid got %b want 1", out_valid3); else n_pass++;
    rst = 1'b1;
    cyc();
    n_checks++; if (out_valid3 !== 1'b0) $display("FAIL tc_rst_valid got %b want 0", out_valid3); else n_pass++;
    n_checks++; if (out_data3 !== 8'h00) $display("FAIL tc_rst_data got %h want 00", out_data3); else n_pass++;
    n_checks++; if (out_valid4 !== 1'b0) $display("FAIL tc_rst_valid4 got %b want 0", out_valid4); else n_pass++;
    rst = 1'b0;
    cyc();
    n_checks++; if (out_ch3 !== 2'd0) $display("FAIL tc_first_ch got %0d want 0", out_ch3); else n_pass++;
    n_checks++; if (out_data3 !== 8'h11) $display("FAIL tc_first_data got %h want 11", out_data3); else n_pass++;
    n_checks++; if (out_ch4 !== 2'd0) $display("FAIL tc_first_ch4 got %0d want 0", out_ch4); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      cyc();
      e = 2'((i + 1) % 3);
      n_checks++; if (out_ch3 !== e) $display("FAIL tc_wrap_ch[%0d] got %0d want %0d", i, out_ch3, e); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      force_en  = ($urandom_range(0, 4) == 0);
      force_sel = 2'($urandom);
      cyc();
    end
    out_ready = 1'b1;
    force_en  = 1'b0;
    in_valid  = 4'b0000;
    cyc();
    cyc();
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = 32'h4433_2211;
    in_valid  = 4'b1111;
    force_en  = 1'b0;
    force_sel = 2'd0;
    out_ready = 1'b1;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_sparse();
    test_force();
    test_three_ch();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
